// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS instruction-fetch stage
//
// Contents:
//   fetch_state_e         fetch FSM states (BOOT, FETCH, FLUSH)
//   NOP                   value held in the IF/ID slot after reset
//   PC_INCR               sequential PC increment (one 32-bit word)
//   DEFAULT_RESET_VECTOR  default PC loaded while reset is high
//   jump_target()         J-format target from the jump's own PC and instr_index

package mips_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP                  = 32'h0000_0000;
  localparam logic [31:0] PC_INCR              = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  // The region bits come from the address of the delay-slot word (jump PC + 4),
  // so a jump sitting in the last word of a 256 MB region lands in the next one.
  function automatic logic [31:0] jump_target(input logic [31:0] instr_pc,
                                              input logic [25:0] instr_index);
    logic [31:0] pc_plus4;
    pc_plus4 = instr_pc + PC_INCR;
    return {pc_plus4[31:28], instr_index, 2'b00};
  endfunction

endpackage

// File: rtl/mips_ifetch_if.sv
// rtl/mips_ifetch_if.sv - instruction-memory read channel between fetch stage and memory
//
// Signals:
//   IMEM_REQ    read request (fetch -> memory), held until IMEM_ACK
//   IMEM_ADDR   word address (fetch -> memory), stable while waiting
//   IMEM_ACK    read complete, IMEM_RDATA valid (memory -> fetch)
//   IMEM_RDATA  read data (memory -> fetch)
// Modports: master = fetch stage, slave = instruction memory.

interface mips_ifetch_if;

  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_ACK;
  logic [31:0] IMEM_RDATA;

  modport master (
    output IMEM_REQ,
    output IMEM_ADDR,
    input  IMEM_ACK,
    input  IMEM_RDATA
  );

  modport slave (
    input  IMEM_REQ,
    input  IMEM_ADDR,
    output IMEM_ACK,
    output IMEM_RDATA
  );

endinterface

// File: rtl/mips_next_pc.sv
// rtl/mips_next_pc.sv - combinational next-PC select: hold, +4, branch or jump
//
// Ports:
//   pc_cur_i         current PC from the PC register
//   instr_pc_i       address of the instruction in the IF/ID slot (jump source)
//   advance_i        a fetch completed this cycle; step to pc_cur_i + 4
//   redirect_en_i    redirects are honoured (not in BOOT)
//   branch_taken_i   branch redirect request
//   branch_target_i  branch target address
//   jump_i           jump redirect request (wins over branch)
//   jump_index_i     J-format instr_index field
//   pc_next_o        selected next PC

module mips_next_pc
  import mips_pkg::*;
(
  input  logic [31:0] pc_cur_i,
  input  logic [31:0] instr_pc_i,
  input  logic        advance_i,
  input  logic        redirect_en_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [25:0] jump_index_i,
  output logic [31:0] pc_next_o
);

  logic [31:0] pc_plus4;
  logic [31:0] jump_tgt;

  always_comb begin
    pc_plus4  = pc_cur_i + PC_INCR;  // modulo 2^32: 32'hFFFF_FFFC wraps to 0
    jump_tgt  = jump_target(instr_pc_i, jump_index_i);
    pc_next_o = pc_cur_i;
    if (redirect_en_i && jump_i) begin
      pc_next_o = jump_tgt;
    end else if (redirect_en_i && branch_taken_i) begin
      pc_next_o = branch_target_i;
    end else if (advance_i) begin
      pc_next_o = pc_plus4;
    end
  end

endmodule

// File: rtl/mips_ifetch.sv
// rtl/mips_ifetch.sv - MIPS instruction-fetch stage wrapped around the PC register
//
// Ports:
//   CLK, RESET      clock; synchronous active-high reset
//   PC_CUR          current PC from the PC register
//   PC_NEXT         next PC to the PC register input (combinational)
//   imem            instruction-memory read channel (mips_ifetch_if.master)
//   STALL           decode cannot accept INSTR this cycle
//   BRANCH_TAKEN    redirect to BRANCH_TARGET
//   BRANCH_TARGET   branch target address
//   JUMP            redirect to the J-format target (wins over BRANCH_TAKEN)
//   JUMP_INDEX      J-format instr_index field
//   INSTR           fetched instruction (IF/ID slot)
//   INSTR_PC        address of INSTR
//   INSTR_VALID     INSTR holds an unconsumed instruction
//   FETCH_ERR       sticky misaligned-PC flag (only with IFETCH_ALIGN_CHECK_EN)
//
// Build option IFETCH_ALIGN_CHECK_EN: misaligned PCs are refused in FETCH and
// flagged on FETCH_ERR. Without it the low two PC bits are dropped from IMEM_ADDR.
//
// The PC register has no enable, so every "stall" here is PC_NEXT = PC_CUR.

module mips_ifetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [31:0]          PC_CUR,
  output logic [31:0]          PC_NEXT,
  mips_ifetch_if.master        imem,
  input  logic                 STALL,
  input  logic                 BRANCH_TAKEN,
  input  logic [31:0]          BRANCH_TARGET,
  input  logic                 JUMP,
  input  logic [25:0]          JUMP_INDEX,
  output logic [31:0]          INSTR,
  output logic [31:0]          INSTR_PC,
  output logic                 INSTR_VALID
`ifdef IFETCH_ALIGN_CHECK_EN
  ,
  output logic                 FETCH_ERR
`endif
);

  fetch_state_e state_q, state_d;
  logic         outstanding_q, outstanding_d;  // request raised and not yet acked
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         valid_q, valid_d;

  logic         slot_free;
  logic         misaligned;
  logic [31:0]  fetch_addr;
  logic         redirect_en;
  logic         redirect;
  logic         advance;
  logic         req;
  logic [31:0]  addr;
  logic [31:0]  pc_sel;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic         err_q, err_d;

  assign misaligned = (PC_CUR[1:0] != 2'b00);
  assign fetch_addr = PC_CUR;
`else
  assign misaligned = 1'b0;
  assign fetch_addr = {PC_CUR[31:2], 2'b00};
`endif

  // A slot being consumed this cycle counts as free, which is what lets a
  // zero-wait memory stream one instruction per cycle.
  assign slot_free   = !valid_q || !STALL;
  assign redirect_en = (state_q != BOOT);
  assign redirect    = redirect_en && (JUMP || BRANCH_TAKEN);

  always_comb begin
    state_d    = state_q;
    req        = 1'b0;
    addr       = fetch_addr;
    advance    = 1'b0;
    valid_d    = valid_q && STALL;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;

    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
      end

      FETCH: begin
        // Once raised, the request is held through STALL; by the time it was
        // raised the slot was free, so it is empty when the data arrives.
        req = !misaligned && (outstanding_q || slot_free);
        if (req && imem.IMEM_ACK && !redirect) begin
          advance    = 1'b1;
          valid_d    = 1'b1;
          instr_d    = imem.IMEM_RDATA;
          instr_pc_d = PC_CUR;
        end
        // The abandoned read must still be completed before fetching the
        // target, and PC_CUR no longer names it, so replay the latched address.
        if (redirect && req && !imem.IMEM_ACK) begin
          state_d = FLUSH;
        end
      end

      FLUSH: begin
        req  = 1'b1;
        addr = req_addr_q;
        if (imem.IMEM_ACK) begin
          state_d = FETCH;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase

    if (redirect) begin
      valid_d = 1'b0;
    end
  end

  assign outstanding_d = req && !imem.IMEM_ACK;
  assign req_addr_d    = (req && !imem.IMEM_ACK) ? addr : req_addr_q;

`ifdef IFETCH_ALIGN_CHECK_EN
  always_comb begin
    err_d = err_q;
    if (redirect) begin
      err_d = 1'b0;
    end else if (state_q == FETCH && misaligned) begin
      err_d = 1'b1;
    end
  end
`endif

  mips_next_pc u_next_pc (
    .pc_cur_i        (PC_CUR),
    .instr_pc_i      (instr_pc_q),
    .advance_i       (advance),
    .redirect_en_i   (redirect_en),
    .branch_taken_i  (BRANCH_TAKEN),
    .branch_target_i (BRANCH_TARGET),
    .jump_i          (JUMP),
    .jump_index_i    (JUMP_INDEX),
    .pc_next_o       (pc_sel)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= BOOT;
      outstanding_q <= 1'b0;
      req_addr_q    <= 32'h0000_0000;
      instr_q       <= NOP;
      instr_pc_q    <= 32'h0000_0000;
      valid_q       <= 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      req_addr_q    <= req_addr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      valid_q       <= valid_d;
`ifdef IFETCH_ALIGN_CHECK_EN
      err_q         <= err_d;
`endif
    end
  end

  assign PC_NEXT        = RESET ? RESET_VECTOR : pc_sel;
  assign imem.IMEM_REQ  = req;
  assign imem.IMEM_ADDR = addr;
  assign INSTR          = instr_q;
  assign INSTR_PC       = instr_pc_q;
  assign INSTR_VALID    = valid_q;
`ifdef IFETCH_ALIGN_CHECK_EN
  assign FETCH_ERR      = err_q;
`endif

endmodule

// File: tb/tb_mips_ifetch.sv
// tb/tb_mips_ifetch.sv - scoreboard testbench for mips_ifetch

module tb_mips_ifetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] pc_q = 32'h0;
  logic [31:0] PC_NEXT;
  logic        STALL = 1'b0;
  logic        BRANCH_TAKEN = 1'b0;
  logic [31:0] BRANCH_TARGET = 32'h0;
  logic        JUMP = 1'b0;
  logic [25:0] JUMP_INDEX = 26'h0;
  logic [31:0] INSTR;
  logic [31:0] INSTR_PC;
  logic        INSTR_VALID;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic        FETCH_ERR;
`endif

  int lat = 0;
  int wait_cnt = 0;
  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  mips_ifetch_if imem ();

  mips_ifetch #(.RESET_VECTOR(32'h0000_0000)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .PC_CUR        (pc_q),
    .PC_NEXT       (PC_NEXT),
    .imem          (imem),
    .STALL         (STALL),
    .BRANCH_TAKEN  (BRANCH_TAKEN),
    .BRANCH_TARGET (BRANCH_TARGET),
    .JUMP          (JUMP),
    .JUMP_INDEX    (JUMP_INDEX),
    .INSTR         (INSTR),
    .INSTR_PC      (INSTR_PC),
    .INSTR_VALID   (INSTR_VALID)
`ifdef IFETCH_ALIGN_CHECK_EN
    ,
    .FETCH_ERR     (FETCH_ERR)
`endif
  );

  always #5 CLK = ~CLK;

  // PC register (no enable) and instruction memory with programmable wait states.
  always @(posedge CLK) pc_q <= PC_NEXT;

  assign imem.IMEM_ACK   = imem.IMEM_REQ && (wait_cnt >= lat);
  assign imem.IMEM_RDATA = imem.IMEM_ADDR ^ 32'hA5A5_A5A5;

  always @(posedge CLK) begin
    if (imem.IMEM_REQ && !imem.IMEM_ACK) wait_cnt <= wait_cnt + 1;
    else                                 wait_cnt <= 0;
  end

  function automatic exp_t mk(input logic [31:0] a);
    exp_t e;
    e.pc    = a;
    e.instr = a ^ 32'hA5A5_A5A5;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  // Monitor: every consumed slot must match the next expected fetch.
  always @(negedge CLK) begin
    if (!RESET && INSTR_VALID && !STALL) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr: got pc %h, expected no instruction", INSTR_PC);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_instr_pc", INSTR_PC, mon_e.pc);
        check("sb_instr", INSTR, mon_e.instr);
      end
    end
  end

  initial begin
    #5000;
    errors++;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    exp_q.push_back(mk(32'h0));
    exp_q.push_back(mk(32'h4));
    exp_q.push_back(mk(32'h8));

    // C0: reset
    tick();
    smp();
    check("rst_pc_next", PC_NEXT, 32'h0);
    check("rst_req", {31'b0, imem.IMEM_REQ}, 32'h0);
    check("rst_valid", {31'b0, INSTR_VALID}, 32'h0);
    check("rst_instr", INSTR, 32'h0);
    check("rst_instr_pc", INSTR_PC, 32'h0);

    // C1: BOOT
    tick(); RESET = 1'b0;
    smp();
    check("boot_req", {31'b0, imem.IMEM_REQ}, 32'h0);
    check("boot_pc_next", PC_NEXT, 32'h0);

    // C2: first zero-wait fetch
    tick();
    smp();
    check("f0_req", {31'b0, imem.IMEM_REQ}, 32'h1);
    check("f0_addr", imem.IMEM_ADDR, 32'h0);
    check("f0_pc_next", PC_NEXT, 32'h4);

    tick(); smp();
    check("c3_valid", {31'b0, INSTR_VALID}, 32'h1);
    tick(); smp();
    check("c4_valid", {31'b0, INSTR_VALID}, 32'h1);

    // C5..C7: stall with slot 0x8 held
    tick(); STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp();
      check("stall_instr_pc", INSTR_PC, 32'h8);
      check("stall_instr", INSTR, 32'h8 ^ 32'hA5A5_A5A5);
      check("stall_req", {31'b0, imem.IMEM_REQ}, 32'h0);
      check("stall_pc_next", PC_NEXT, 32'hC);
      if (i < 2) tick();
    end

    // C8..C11: release stall, 2-cycle ACK latency
    tick(); STALL = 1'b0; lat = 2;
    exp_q.push_back(mk(32'hC));
    smp();
    check("w0_addr", imem.IMEM_ADDR, 32'hC);
    check("w0_pc_next", PC_NEXT, 32'hC);
    tick(); smp();
    check("w1_req", {31'b0, imem.IMEM_REQ}, 32'h1);
    check("w1_addr", imem.IMEM_ADDR, 32'hC);
    check("w1_pc_next", PC_NEXT, 32'hC);
    check("w1_valid", {31'b0, INSTR_VALID}, 32'h0);
    tick(); smp();
    check("w2_ack", {31'b0, imem.IMEM_ACK}, 32'h1);
    check("w2_pc_next", PC_NEXT, 32'h10);
    tick(); smp();
    check("w3_valid", {31'b0, INSTR_VALID}, 32'h1);

    // C12: reset while the request to 0x10 is outstanding
    tick(); RESET = 1'b1;
    exp_q.push_back(mk(32'h0));
    exp_q.push_back(mk(32'h4));
    exp_q.push_back(mk(32'h100));
    smp();
    check("mid_req", {31'b0, imem.IMEM_REQ}, 32'h1);
    check("mid_rst_pc_next", PC_NEXT, 32'h0);
    check("mid_valid", {31'b0, INSTR_VALID}, 32'h0);

    // C13: after reset edge
    tick(); RESET = 1'b0;
    smp();
    check("postrst_req", {31'b0, imem.IMEM_REQ}, 32'h0);
    check("postrst_valid", {31'b0, INSTR_VALID}, 32'h0);

    // C20: branch to 0x100 while request to 0x8 waits
    repeat (7) tick();
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h0000_0100;
    smp();
    check("br_addr", imem.IMEM_ADDR, 32'h8);
    check("br_ack", {31'b0, imem.IMEM_ACK}, 32'h0);
    check("br_pc_next", PC_NEXT, 32'h100);

    // C21, C22: FLUSH replays 0x8
    tick(); BRANCH_TAKEN = 1'b0;
    smp();
    check("fl0_req", {31'b0, imem.IMEM_REQ}, 32'h1);
    check("fl0_addr", imem.IMEM_ADDR, 32'h8);
    check("fl0_pc_next", PC_NEXT, 32'h100);
    tick(); smp();
    check("fl1_addr", imem.IMEM_ADDR, 32'h8);
    check("fl1_ack", {31'b0, imem.IMEM_ACK}, 32'h1);
    check("fl1_pc_next", PC_NEXT, 32'h100);
    tick(); smp();
    check("fl_discard_valid", {31'b0, INSTR_VALID}, 32'h0);
    check("fl_target_addr", imem.IMEM_ADDR, 32'h100);

    // C26: branch with same-cycle ACK, zero-wait from here
    repeat (3) tick();
    lat = 0;
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'hF000_0010;
    exp_q.push_back(mk(32'hF000_0010));
    exp_q.push_back(mk(32'hF000_0100));
    exp_q.push_back(mk(32'hFFFF_FFFC));
    exp_q.push_back(mk(32'h0));
    smp();
    check("br2_pc_next", PC_NEXT, 32'hF000_0010);

    tick(); BRANCH_TAKEN = 1'b0;
    smp();
    check("same_ack_discard", {31'b0, INSTR_VALID}, 32'h0);
    check("br2_addr", imem.IMEM_ADDR, 32'hF000_0010);
    check("br2_step", PC_NEXT, 32'hF000_0014);

    // C28: JUMP and BRANCH_TAKEN together, jump wins
    tick();
    JUMP = 1'b1; JUMP_INDEX = 26'h000_0040;
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h0000_0200;
    smp();
    check("jump_pc_next", PC_NEXT, 32'hF000_0100);

    tick(); JUMP = 1'b0; BRANCH_TAKEN = 1'b0;
    smp();
    check("jump_squash", {31'b0, INSTR_VALID}, 32'h0);
    check("jump_addr", imem.IMEM_ADDR, 32'hF000_0100);

    // C30, C31: wrap at top of address space
    tick(); BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'hFFFF_FFFC;
    smp();
    check("br3_pc_next", PC_NEXT, 32'hFFFF_FFFC);
    tick(); BRANCH_TAKEN = 1'b0;
    smp();
    check("wrap_addr", imem.IMEM_ADDR, 32'hFFFF_FFFC);
    check("wrap_pc_next", PC_NEXT, 32'h0);
    tick(); smp();
    check("after_wrap_pc_next", PC_NEXT, 32'h4);

    // C34: park with slot 0x4 held
    tick();
    tick(); STALL = 1'b1;
    smp();
    check("park_valid", {31'b0, INSTR_VALID}, 32'h1);
    check("park_instr_pc", INSTR_PC, 32'h4);
    tick(); smp();
    check("sb_drained", exp_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_ifetch.md
Name: mips_ifetch

Overview:
Instruction-fetch stage wrapped around the MIPS program-counter register.
- Consumes the registered PC (PC_CUR) and issues word reads to instruction memory over a REQ/ACK handshake.
- Registers the returned instruction into an IF/ID output slot for decode.
- Computes PC_NEXT for the PC register's input: hold, PC+4, branch or jump redirect.
- The PC register has no enable, so this block stalls the PC by driving PC_NEXT = PC_CUR.

Parameters:
RESET_VECTOR, 32'h0000_0000, value driven on PC_NEXT while RESET is high.

Ports:
CLK  in  1  system clock; all state changes on the rising edge
RESET  in  1  synchronous, active-high reset
PC_CUR  in  32  current PC from the PC register
PC_NEXT  out  32  next PC to the PC register input (combinational)
IMEM_REQ  out  1  read request to instruction memory
IMEM_ADDR  out  32  read word address; stable while IMEM_REQ is high and IMEM_ACK is low
IMEM_ACK  in  1  read complete; IMEM_RDATA valid this cycle; may be asserted in the same cycle as IMEM_REQ
IMEM_RDATA  in  32  read data
STALL  in  1  decode cannot accept INSTR this cycle
BRANCH_TAKEN  in  1  redirect to BRANCH_TARGET
BRANCH_TARGET  in  32  branch target (computed by decode)
JUMP  in  1  redirect to jump target
JUMP_INDEX  in  26  J-format instr_index field
INSTR  out  32  fetched instruction (IF/ID)
INSTR_PC  out  32  address of INSTR
INSTR_VALID  out  1  INSTR holds an unconsumed instruction

Behaviour:
- Clock and reset: single clock CLK; reset is synchronous and active-high on RESET.
- Reset values:
  - State = BOOT.
  - IMEM_REQ = 0, INSTR = 32'h0000_0000 (NOP), INSTR_PC = 0, INSTR_VALID = 0.
  - Latched request address = 0.
  - While RESET is high, PC_NEXT = RESET_VECTOR.
- Consume rule: the slot is consumed when INSTR_VALID && !STALL; INSTR_VALID clears next cycle unless refilled.
- Slot free this cycle: !INSTR_VALID || !STALL.
- States:
  - BOOT: one cycle; IMEM_REQ = 0; PC_NEXT = PC_CUR; go to FETCH.
  - FETCH:
    - IMEM_ADDR = PC_CUR.
    - IMEM_REQ = 1 if the request is already outstanding, or if the slot is free.
    - Once raised, IMEM_REQ stays high until IMEM_ACK, regardless of STALL (slot is guaranteed empty by then).
    - Without ACK: PC_NEXT = PC_CUR.
    - On ACK: INSTR <= IMEM_RDATA, INSTR_PC <= PC_CUR, INSTR_VALID <= 1, PC_NEXT = PC_CUR + 4.
  - FLUSH:
    - Entered when a redirect occurs while a request is outstanding and IMEM_ACK = 0.
    - IMEM_REQ = 1 and IMEM_ADDR = latched request address until ACK.
    - ACK data is discarded; INSTR_VALID stays 0; PC_NEXT = PC_CUR (already the target).
    - On ACK, return to FETCH.
- Redirect (BRANCH_TAKEN or JUMP), any state except BOOT:
  - JUMP has priority over BRANCH_TAKEN.
  - Jump target = {INSTR_PC_plus4[31:28], JUMP_INDEX, 2'b00}, where INSTR_PC_plus4 = INSTR_PC + 4.
  - PC_NEXT = target; INSTR_VALID <= 0 (squash).
  - Data on a same-cycle ACK is discarded.
- Latched request address: captured every cycle IMEM_REQ && !IMEM_ACK.
- Arithmetic: all PC additions are 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Latency: a zero-wait memory gives one instruction per cycle. INSTR is valid the cycle after ACK.
- Reset mid-request: state, slot and IMEM_REQ clear next cycle. The memory must tolerate an abandoned request.

Optional Feature:
IFETCH_ALIGN_CHECK_EN
- Defined:
  - Adds output FETCH_ERR (1 bit, reset 0).
  - In FETCH, if PC_CUR[1:0] != 0: no request, PC_NEXT = PC_CUR, FETCH_ERR <= 1 (sticky until RESET or redirect).
- Undefined:
  - No FETCH_ERR port.
  - IMEM_ADDR = {PC_CUR[31:2], 2'b00}; low bits are ignored.

Decomposition:
- Shared package mips_pkg holds:
  - state enum {BOOT, FETCH, FLUSH}
  - NOP constant 32'h0000_0000
  - PC increment constant 4
  - default reset vector
- One sub-module, mips_next_pc: combinational next-PC mux and adders (hold / +4 / branch / jump with JUMP priority). The FSM and slot stay in mips_ifetch.

Test Plan:
- Reset, then zero-wait memory returning mem[a] = a ^ 32'hA5A5_A5A5 -> after BOOT, INSTR_PC = 0, 4, 8 on consecutive cycles; INSTR matches.
- ACK delayed 2 cycles -> IMEM_ADDR stable, PC_NEXT = PC_CUR during wait, INSTR_VALID pulses once per fetch.
- STALL held 3 cycles with a valid slot -> INSTR/INSTR_PC unchanged, no new request, PC frozen; fetch resumes on release.
- BRANCH_TAKEN (target 32'h0000_0100) while a request to 0x8 is outstanding with 2-cycle ACK latency:
  - FLUSH keeps IMEM_ADDR = 0x8; its data is discarded.
  - The next valid INSTR_PC is 0x100.
- JUMP with INSTR_PC = 32'hF000_0010, JUMP_INDEX = 26'h0000040 -> PC_NEXT = 32'hF000_0100; JUMP and BRANCH_TAKEN together -> the jump wins.
- RESET asserted mid-request -> next cycle IMEM_REQ = 0, INSTR_VALID = 0, PC_NEXT = RESET_VECTOR while reset is high.
